ripple_cascade_counter: RTL and testbench

//  Upper stage of a cascaded modulo-(TERM+1) up/down counter chain.

---
 rtl/ripple_cascade_counter.sv | 77 +++++++
 tb/tb_ripple_cascade_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ripple_cascade_counter.sv
// Upper stage of a cascaded modulo-(TERM+1) up/down counter chain with parallel
// load, saturating wrap counter and sticky load-clamp flag.
module ripple_cascade_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned TERM  = 20,
    parameter int unsigned EDGE  = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             ctrl,
    input  logic             ripple_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ripple_out,
    output logic [7:0]       wraps,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

    logic [WIDTH-1:0] count_q, count_d;
    logic [7:0]       wraps_q, wraps_d;
    logic             load_err_q, load_err_d;
    logic             ripple_in_q;
    logic             step;
    logic             at_term;

    always_comb begin
        step    = (EDGE != 0) ? (ripple_in & ~ripple_in_q) : ripple_in;
        at_term = ctrl ? (count_q == '0) : (count_q == TERM_V);
        // High in exactly the cycle this stage wraps, so the next stage steps with no added latency.
        ripple_out = step & ~clear & ~load & at_term;
    end

    always_comb begin
        count_d    = count_q;
        wraps_d    = wraps_q;
        load_err_d = load_err_q;
        if (load) begin
            if (load_val > TERM_V) begin
                count_d    = TERM_V;
                load_err_d = 1'b1;
            end else begin
                count_d = load_val;
            end
        end else if (step) begin
            if (at_term) begin
                count_d = ctrl ? TERM_V : '0;
                if (wraps_q != '1) begin
                    wraps_d = wraps_q + 8'd1;
                end
            end else begin
                count_d = ctrl ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q     <= '0;
            wraps_q     <= '0;
            load_err_q  <= 1'b0;
            ripple_in_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wraps_q     <= wraps_d;
            load_err_q  <= load_err_d;
            ripple_in_q <= ripple_in;
        end
    end

    assign count    = count_q;
    assign wraps    = wraps_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_ripple_cascade_counter.sv
// Bench for ripple_cascade_counter: level- and edge-enabled stages against a
// behavioural model, plus a two-stage chain checked against a total step count.
module tb_ripple_cascade_counter;

    localparam int TERM = 20;
    localparam int MOD  = TERM + 1;

    logic       clk = 1'b0;
    logic       clear = 1'b0, ctrl = 1'b0, ripple_in = 1'b0, load = 1'b0;
    logic [5:0] load_val = '0;
    logic [5:0] cnt_l, cnt_e;
    logic [7:0] wr_l, wr_e;
    logic       ro_l, ro_e, err_l, err_e;

    logic       clear_c = 1'b0, en_c = 1'b0;
    logic       ctrl_c = 1'b0, load_c = 1'b0;
    logic [5:0] lv_c = '0;
    logic [5:0] cnt_lo, cnt_hi;
    logic [7:0] wr_lo, wr_hi;
    logic       ro_lo, ro_hi, err_lo, err_hi;

    int checks = 0;
    int failures = 0;

    int m_cnt[2], m_wr[2], m_err[2], m_prev[2], m_st[2], exp_ro[2];
    int n_steps = 0;

    always #5 clk = ~clk;

    ripple_cascade_counter #(.WIDTH(6), .TERM(TERM), .EDGE(0)) dut_lvl (
        .clk(clk), .clear(clear), .ctrl(ctrl), .ripple_in(ripple_in), .load(load),
        .load_val(load_val), .count(cnt_l), .ripple_out(ro_l), .wraps(wr_l), .load_err(err_l));

    ripple_cascade_counter #(.WIDTH(6), .TERM(TERM), .EDGE(1)) dut_edg (
        .clk(clk), .clear(clear), .ctrl(ctrl), .ripple_in(ripple_in), .load(load),
        .load_val(load_val), .count(cnt_e), .ripple_out(ro_e), .wraps(wr_e), .load_err(err_e));

    ripple_cascade_counter #(.WIDTH(6), .TERM(TERM), .EDGE(0)) dut_lo (
        .clk(clk), .clear(clear_c), .ctrl(ctrl_c), .ripple_in(en_c), .load(load_c),
        .load_val(lv_c), .count(cnt_lo), .ripple_out(ro_lo), .wraps(wr_lo), .load_err(err_lo));

    ripple_cascade_counter #(.WIDTH(6), .TERM(TERM), .EDGE(0)) dut_hi (
        .clk(clk), .clear(clear_c), .ctrl(ctrl_c), .ripple_in(ro_lo), .load(load_c),
        .load_val(lv_c), .count(cnt_hi), .ripple_out(ro_hi), .wraps(wr_hi), .load_err(err_hi));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock of shared stimulus for the level and edge stages.
    task automatic drive(input bit clr, input bit ld, input int lv, input bit dir, input bit rin);
        clear = clr; load = ld; load_val = 6'(lv); ctrl = dir; ripple_in = rin;
        #1;
        for (int k = 0; k < 2; k++) begin
            m_st[k]   = (k == 1) ? int'(rin && (m_prev[k] == 0)) : int'(rin);
            exp_ro[k] = int'(!clr && !ld && (m_st[k] != 0) &&
                             (dir ? (m_cnt[k] == 0) : (m_cnt[k] == TERM)));
        end
        chk("ro_lvl", int'(ro_l), exp_ro[0]);
        chk("ro_edg", int'(ro_e), exp_ro[1]);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_cnt[k] = 0; m_wr[k] = 0; m_err[k] = 0; m_prev[k] = 0;
            end else begin
                m_prev[k] = int'(rin);
                if (ld) begin
                    m_cnt[k] = (lv > TERM) ? TERM : lv;
                    if (lv > TERM) m_err[k] = 1;
                end else if (m_st[k] != 0) begin
                    if (dir ? (m_cnt[k] == 0) : (m_cnt[k] == TERM))
                        m_wr[k] = (m_wr[k] < 255) ? m_wr[k] + 1 : 255;
                    m_cnt[k] = (m_cnt[k] + (dir ? TERM : 1)) % MOD;
                end
            end
        end
        chk("cnt_lvl", int'(cnt_l), m_cnt[0]);
        chk("cnt_edg", int'(cnt_e), m_cnt[1]);
        chk("wr_lvl", int'(wr_l), m_wr[0]);
        chk("wr_edg", int'(wr_e), m_wr[1]);
        chk("err_lvl", int'(err_l), m_err[0]);
        chk("err_edg", int'(err_e), m_err[1]);
    endtask

    // Chain state follows purely from the total number of lower-stage steps.
    task automatic chain_cycle(input bit clr, input bit en);
        int lo, hi;
        clear_c = clr; en_c = en;
        #1;
        lo = n_steps % MOD;
        hi = (n_steps / MOD) % MOD;
        chk("ro_lo", int'(ro_lo), int'(!clr && en && lo == TERM));
        chk("ro_hi", int'(ro_hi), int'(!clr && en && lo == TERM && hi == TERM));
        @(posedge clk); #1;
        if (clr) n_steps = 0;
        else if (en) n_steps++;
        chk("cnt_lo", int'(cnt_lo), n_steps % MOD);
        chk("cnt_hi", int'(cnt_hi), (n_steps / MOD) % MOD);
        chk("wr_lo", int'(wr_lo), (n_steps / MOD > 255) ? 255 : n_steps / MOD);
        chk("wr_hi", int'(wr_hi), n_steps / (MOD * MOD));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_wr[k] = 0; m_err[k] = 0; m_prev[k] = 0;
        end

        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        for (int i = 0; i < 22; i++) drive(0, 0, 0, 0, 1);

        drive(1, 0, 0, 0, 0);
        drive(0, 1, 3, 1, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1);

        drive(0, 1, 45, 0, 0);
        drive(0, 1, 5, 0, 0);
        drive(0, 1, 20, 0, 0);
        drive(0, 1, 9, 0, 1);

        drive(1, 0, 0, 0, 0);
        drive(0, 1, 7, 0, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 20, 1, 0);
        drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 63)), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 20, 0, 0);
            drive(0, 0, 0, 0, 1);
        end
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);

        chain_cycle(1, 0);
        chain_cycle(1, 1);
        while (n_steps < 441) chain_cycle(0, 1);
        for (int i = 0; i < 600; i++) chain_cycle(($urandom_range(0, 499) == 0), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
